// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the architectural PC, keeps at most one fetch
// in flight and hands each fetched word to decode together with its PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. Valid never depends on ready in this block. While the request is
  // not yet accepted its address may change after a redirect. Decode-side data
  // is held stable while out_valid is high unless a redirect squashes it.

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        discard_q, discard_d;
  logic [31:0] redir_target;
  logic        unused_redirect_lsbs;

  assign redir_target         = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    discard_d   = discard_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redir_target;
        end
        // An accepted address that was redirected in the same cycle is stale.
        if (imem_req_ready) begin
          state_d   = S_WAIT;
          discard_d = redirect_valid;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = redir_target;
          if (imem_rsp_valid) begin
            state_d   = S_REQ;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            out_pc_d    = pc_q;
            out_instr_d = imem_rsp_data;
            pc_d        = pc_q + 32'd4;
            state_d     = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          pc_d    = redir_target;
          state_d = S_REQ;
        end else if (out_ready) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      out_pc_q    <= 32'h0000_0000;
      out_instr_q <= NOP;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      discard_q   <= discard_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign out_valid      = (state_q == S_OUT);
  assign out_pc         = out_pc_q;
  assign out_instr      = out_instr_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: bench-side instruction memory, a PC-stream reference
// model checked on every decode handshake, directed scenarios then random traffic.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [1:0]  dbg_state_unused;

  int tests = 0;
  int fails = 0;

  // reference model and memory model state
  logic [31:0] ref_pc;
  int          since_rst;
  int          hs_count;
  logic [31:0] exp_q[$];
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          lat_min, lat_max;
  logic        rand_ready, rand_out;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .dbg_state_o(dbg_state_unused)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1357, a[31:16] ^ 16'hC0DE};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: sample at the falling edge, then drive memory outputs after the rising edge.
  task automatic tick();
    @(negedge clk);
    chk("req_while_out", {31'd0, imem_req_valid && out_valid}, 32'd0);
    if (!rst_n) begin
      ref_pc    = RST_PC;
      since_rst = 0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, ref_pc);
        pend      = 1'b1;
        pend_addr = imem_req_addr;
        pend_cnt  = $urandom_range(lat_max, lat_min);
      end
      if (out_valid && out_ready) begin
        chk("hs_pc", out_pc, ref_pc);
        chk("hs_instr", out_instr, mem_word(ref_pc));
        if (exp_q.size() > 0) chk("hs_directed_pc", out_pc, exp_q.pop_front());
        hs_count++;
        ref_pc = ref_pc + 32'd4;
      end
      if (redirect_valid && since_rst != 0) ref_pc = {redirect_pc[31:2], 2'b00};
      since_rst++;
    end
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (pend) begin
      if (pend_cnt <= 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        pend           = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (rand_ready) imem_req_ready = 1'($urandom_range(0, 1));
    if (rand_out) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_out_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
  endtask

  initial begin
    logic [31:0] held_pc, held_instr;
    int hs0;
    rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    ref_pc = RST_PC; since_rst = 0; hs_count = 0; pend = 1'b0; pend_addr = 32'h0; pend_cnt = 0;
    lat_min = 1; lat_max = 1; rand_ready = 1'b0; rand_out = 1'b0;

    // reset values
    tick();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0000_0013);
    chk("rst_addr", imem_req_addr, RST_PC);

    // best-case streaming: one instruction every third cycle
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    rst_n = 1'b1;
    chk("idle_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk("first_req", {31'd0, imem_req_valid}, 32'd1);
    chk("first_addr", imem_req_addr, 32'h100);
    tick();
    chk("c2_no_out", {31'd0, out_valid}, 32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_pc", out_pc, 32'h100 + 32'(4 * k));
      chk("stream_instr", out_instr, mem_word(32'h100 + 32'(4 * k)));
      if (k < 2) begin
        tick();
        chk("stream_gap", {31'd0, out_valid}, 32'd0);
        tick();
        tick();
      end
    end

    // decode stall holds the instruction and blocks new requests
    out_ready = 1'b0;
    held_pc = out_pc; held_instr = out_instr;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_pc", out_pc, held_pc);
      chk("stall_instr", out_instr, held_instr);
      chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("stall_next_req", {31'd0, imem_req_valid}, 32'd1);
    chk("stall_next_addr", imem_req_addr, held_pc + 32'd4);

    // redirect while waiting: stale response dropped, refetch from target
    lat_min = 3; lat_max = 3;
    tick();
    chk("wait_state", {30'd0, imem_req_valid, out_valid}, 32'd0);
    lat_min = 1; lat_max = 1;
    redirect(32'h2002);
    exp_q.push_back(32'h2000);
    tick();
    chk("wait_disc1", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk("wait_disc2", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk("wait_redir_req", {31'd0, imem_req_valid}, 32'd1);
    chk("wait_redir_addr", imem_req_addr, 32'h2000);
    wait_out_valid("wait_redir_timeout");
    chk("wait_redir_out_pc", out_pc, 32'h2000);

    // redirect coinciding with request handshake
    imem_req_ready = 1'b0;
    tick();
    redirect(32'h10);
    tick();
    chk("hold_req", {31'd0, imem_req_valid}, 32'd1);
    chk("hold_addr", imem_req_addr, 32'h10);
    imem_req_ready = 1'b1;
    redirect(32'h400);
    exp_q.push_back(32'h400);
    tick();
    chk("hs_redir_wait", {31'd0, imem_req_valid}, 32'd0);
    wait_out_valid("hs_redir_timeout");
    chk("hs_redir_pc", out_pc, 32'h400);
    chk("hs_redir_instr", out_instr, mem_word(32'h400));

    // redirect in OUT with decode accepting
    hs0 = hs_count;
    redirect(32'h800);
    tick();
    chk("out_redir_hs", 32'(hs_count), 32'(hs0 + 1));
    chk("out_redir_addr", imem_req_addr, 32'h800);
    exp_q.push_back(32'h800);
    wait_out_valid("out_redir_timeout");
    chk("out_redir_pc", out_pc, 32'h800);

    // redirect in OUT with decode stalled: instruction squashed
    out_ready = 1'b0;
    hs0 = hs_count;
    redirect(32'hC00);
    tick();
    chk("squash_valid", {31'd0, out_valid}, 32'd0);
    chk("squash_no_hs", 32'(hs_count), 32'(hs0));
    chk("squash_addr", imem_req_addr, 32'hC00);
    out_ready = 1'b1;
    exp_q.delete();
    exp_q.push_back(32'hC00);
    wait_out_valid("squash_timeout");
    chk("squash_next_pc", out_pc, 32'hC00);

    // PC wraps modulo 2^32
    redirect(32'hFFFF_FFFF);
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    tick();
    wait_out_valid("wrap_timeout");
    chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_next_addr", imem_req_addr, 32'h0);
    wait_out_valid("wrap_timeout2");
    chk("wrap_zero_pc", out_pc, 32'h0);

    // reset during WAIT; redirect during the IDLE cycle is ignored
    lat_min = 3; lat_max = 3;
    tick();
    tick();
    chk("pre_rst_wait", {30'd0, imem_req_valid, out_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_pc", out_pc, 32'h0);
    chk("mid_rst_out_instr", out_instr, 32'h0000_0013);
    chk("mid_rst_addr", imem_req_addr, RST_PC);
    exp_q.delete();
    exp_q.push_back(RST_PC);
    tick();
    rst_n = 1'b1;
    redirect(32'h5000);
    chk("post_rst_idle", {31'd0, imem_req_valid}, 32'd0);
    tick();
    lat_min = 1; lat_max = 1;
    chk("post_rst_req", {31'd0, imem_req_valid}, 32'd1);
    chk("post_rst_addr", imem_req_addr, RST_PC);
    wait_out_valid("post_rst_timeout");
    chk("post_rst_pc", out_pc, RST_PC);

    // random traffic against the reference model
    lat_min = 1; lat_max = 4; rand_ready = 1'b1; rand_out = 1'b1;
    hs0 = hs_count;
    for (int i = 0; i < 600; i++) begin
      tick();
      if ($urandom_range(0, 7) == 0) redirect($urandom);
    end
    chk("rand_progress", {31'd0, hs_count > hs0 + 20}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
